// File: rtl/store_narrow_unit.sv
// Purpose: narrows a 64-bit store operand to SB/SH/SW/SD, lane-aligns it, builds
//          the byte strobe and issues one or two doubleword write beats.
// Latency: accept at edge T -> beat0 valid in T+1; done in T+2 (one beat) or T+3 (split).
// Backpressure: beat address/data/mask hold while mem_ready=0; req_ready=1 only in IDLE.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          store request handshake
//   req_addr, req_data, req_size byte address, source register, size (00=B..11=D)
//   mem_valid/mem_ready          write beat handshake
//   mem_addr, mem_wdata, mem_wmask doubleword-aligned address, lane data, byte strobe
//   done, split, busy            completion pulse, two-beat qualifier, non-idle flag
module store_narrow_unit #(
  parameter int XLEN = 64,
  parameter int AW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic [1:0]      req_size,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  output logic            done,
  output logic            split,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Only the doubleword base is kept; the byte offset is already folded
  // into the lane-shifted data and mask at capture time.
  logic [AW-1:0]   base_q, base_d;
  logic [XLEN-1:0] lo_dat_q, lo_dat_d;
  logic [XLEN-1:0] hi_dat_q, hi_dat_d;
  logic [7:0]      lo_msk_q, lo_msk_d;
  logic [7:0]      hi_msk_q, hi_msk_d;
  logic            split_q, split_d;

  // Capture-side lane computation
  logic [2:0]        off;
  logic [XLEN-1:0]   narrow_dat;
  logic [15:0]       size_msk;
  logic [2*XLEN-1:0] shift_dat;
  logic [15:0]       byte_msk;
  logic              accept;

  always_comb begin
    off        = req_addr[2:0];
    narrow_dat = '0;
    size_msk   = 16'h0000;
    case (req_size)
      2'b00: begin
        narrow_dat = {{(XLEN-8){1'b0}}, req_data[7:0]};
        size_msk   = 16'h0001;
      end
      2'b01: begin
        narrow_dat = {{(XLEN-16){1'b0}}, req_data[15:0]};
        size_msk   = 16'h0003;
      end
      2'b10: begin
        narrow_dat = {{(XLEN-32){1'b0}}, req_data[31:0]};
        size_msk   = 16'h000F;
      end
      default: begin
        narrow_dat = req_data;
        size_msk   = 16'h00FF;
      end
    endcase
    // 128-bit window: low half is beat0, high half spills into beat1
    shift_dat = {{XLEN{1'b0}}, narrow_dat} << {off, 3'b000};
    byte_msk  = size_msk << off;
  end

  assign accept = req_valid && (state_q == IDLE);

  // Datapath capture
  always_comb begin
    base_d   = base_q;
    lo_dat_d = lo_dat_q;
    hi_dat_d = hi_dat_q;
    lo_msk_d = lo_msk_q;
    hi_msk_d = hi_msk_q;
    split_d  = split_q;
    if (accept) begin
      base_d   = {req_addr[AW-1:3], 3'b000};
      lo_dat_d = shift_dat[XLEN-1:0];
      hi_dat_d = shift_dat[2*XLEN-1:XLEN];
      lo_msk_d = byte_msk[7:0];
      hi_msk_d = byte_msk[15:8];
      split_d  = (byte_msk[15:8] != 8'h00);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      lo_dat_q <= '0;
      hi_dat_q <= '0;
      lo_msk_q <= '0;
      hi_msk_q <= '0;
      split_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      lo_dat_q <= lo_dat_d;
      hi_dat_q <= hi_dat_d;
      lo_msk_q <= lo_msk_d;
      hi_msk_q <= hi_msk_d;
      split_q  <= split_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = BEAT0;
      BEAT0: if (mem_ready) state_d = split_q ? BEAT1 : FIN;
      BEAT1: if (mem_ready) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything outside the beat states reads as zero
  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = 8'h00;
    done      = 1'b0;
    split     = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = base_q;
        mem_wdata = lo_dat_q;
        mem_wmask = lo_msk_q;
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = base_q + AW'(8);  // wraps modulo 2^AW
        mem_wdata = hi_dat_q;
        mem_wmask = hi_msk_q;
      end
      FIN: begin
        done  = 1'b1;
        split = split_q;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Purpose: self-checking bench for store_narrow_unit; byte-level reference model
//          plus directed literal checks on the documented store scenarios.
// Timing: inputs driven #1 after posedge (or at negedge), outputs sampled at negedge.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        done;
  logic        split;
  logic        busy;

  store_narrow_unit #(.XLEN(64), .AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .done      (done),
    .split     (split),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expected beats derived byte by byte from the address
  logic [31:0] ea_q[$];
  logic [63:0] ed_q[$];
  logic [7:0]  em_q[$];
  bit          mon_en    = 1'b0;
  bit          exp_done  = 1'b0;
  bit          exp_split = 1'b0;
  bit          cur_split = 1'b0;

  task automatic model_push(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    logic [63:0] lo_d, hi_d;
    logic [7:0]  lo_m, hi_m;
    logic [31:0] base;
    int off, n, p;
    lo_d = '0; hi_d = '0; lo_m = '0; hi_m = '0;
    off  = int'(a[2:0]);
    n    = 1 << s;
    for (int i = 0; i < n; i++) begin
      p = off + i;
      if (p < 8) begin
        lo_d[8*p +: 8] = d[8*i +: 8];
        lo_m[p]        = 1'b1;
      end else begin
        hi_d[8*(p-8) +: 8] = d[8*i +: 8];
        hi_m[p-8]          = 1'b1;
      end
    end
    base = a & ~32'h7;
    ea_q.push_back(base); ed_q.push_back(lo_d); em_q.push_back(lo_m);
    if (hi_m != 8'h00) begin
      ea_q.push_back(base + 32'd8); ed_q.push_back(hi_d); em_q.push_back(hi_m);
    end
    cur_split = (hi_m != 8'h00);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (mon_en) begin
      if (ea_q.size() > 0) begin
        chk("m_valid", 64'(mem_valid), 64'd1);
        chk("m_addr",  64'(mem_addr),  64'(ea_q[0]));
        chk("m_wdata", mem_wdata,      ed_q[0]);
        chk("m_wmask", 64'(mem_wmask), 64'(em_q[0]));
      end else begin
        chk("m_idle_valid", 64'(mem_valid), 64'd0);
        chk("m_idle_wdata", mem_wdata,      64'd0);
        chk("m_idle_wmask", 64'(mem_wmask), 64'd0);
      end
      chk("m_done",  64'(done),  64'(exp_done));
      chk("m_split", 64'(split), exp_done ? 64'(exp_split) : 64'd0);
      chk("m_ready_vs_busy", 64'(req_ready), 64'(!busy));
      exp_done = 1'b0;
      if (rst) begin
        ea_q.delete(); ed_q.delete(); em_q.delete();
      end else begin
        if (mem_valid && mem_ready && ea_q.size() > 0) begin
          void'(ea_q.pop_front()); void'(ed_q.pop_front()); void'(em_q.pop_front());
          if (ea_q.size() == 0) begin
            exp_done  = 1'b1;
            exp_split = cur_split;
          end
        end
        if (req_valid && req_ready) model_push(req_addr, req_data, req_size);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    int k;
    req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: got req_ready=0 for 20 cycles, required 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done in 50 cycles, required done");
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_beat(input string name, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    chk({name, "_valid"}, 64'(mem_valid), 64'd1);
    chk({name, "_addr"},  64'(mem_addr),  64'(a));
    chk({name, "_wdata"}, mem_wdata,      d);
    chk({name, "_wmask"}, 64'(mem_wmask), 64'(m));
  endtask

  task automatic chk_done(input string name, input logic sp);
    chk({name, "_done"},  64'(done),  64'd1);
    chk({name, "_split"}, 64'(split), 64'(sp));
  endtask

  // Extra vectors exercising the model: {addr, data, size}
  logic [31:0] v_addr [4] = '{32'h10000005, 32'h20000007, 32'h30000004, 32'h40000007};
  logic [63:0] v_data [4] = '{64'hCAFEF00D12345678, 64'h0000000000007E81,
                              64'hFFFFFFFF89ABCDEF, 64'h00000000000000C3};
  logic [1:0]  v_size [4] = '{2'b11, 2'b01, 2'b10, 2'b00};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_wdata",     mem_wdata,      64'd0);
    chk("rst_wmask",     64'(mem_wmask), 64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_split",     64'(split),     64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SB misaligned, upper data discarded
    send(32'h80000003, 64'hFFFFFFFFFFFFFFA5, 2'b00);
    @(negedge clk); chk_beat("sb", 32'h80000000, 64'h00000000A5000000, 8'h08);
    @(negedge clk); chk_done("sb", 1'b0);

    // SD aligned
    send(32'h80000010, 64'h0123456789ABCDEF, 2'b11);
    @(negedge clk); chk_beat("sd", 32'h80000010, 64'h0123456789ABCDEF, 8'hFF);
    @(negedge clk); chk_done("sd", 1'b0);

    // SW crossing a doubleword
    send(32'h80000006, 64'hDEADBEEF11223344, 2'b10);
    @(negedge clk); chk_beat("sw_b0", 32'h80000000, 64'h3344000000000000, 8'hC0);
    @(negedge clk); chk_beat("sw_b1", 32'h80000008, 64'h0000000000001122, 8'h03);
    @(negedge clk); chk_done("sw", 1'b1);

    // Backpressure: three stalled cycles, a second request ignored meanwhile
    mem_ready = 1'b0;
    send(32'h80000000, 64'h000000000000BEEF, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_beat("bp_hold", 32'h80000000, 64'h000000000000BEEF, 8'h03);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      if (i == 0) begin
        req_addr = 32'h90000001; req_data = 64'h5555; req_size = 2'b01; req_valid = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk); chk_beat("bp_go", 32'h80000000, 64'h000000000000BEEF, 8'h03);
    @(negedge clk); chk_done("bp", 1'b0);

    // Address wrap on the second beat
    send(32'hFFFFFFFF, 64'h000000000000AABB, 2'b01);
    @(negedge clk); chk_beat("wrap_b0", 32'hFFFFFFF8, 64'hBB00000000000000, 8'h80);
    @(negedge clk); chk_beat("wrap_b1", 32'h00000000, 64'h00000000000000AA, 8'h01);
    @(negedge clk); chk_done("wrap", 1'b1);

    // Reset while BEAT1 is stalled
    send(32'h80000006, 64'hDEADBEEF11223344, 2'b10);
    @(negedge clk); chk_beat("rb_b0", 32'h80000000, 64'h3344000000000000, 8'hC0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk); chk_beat("rb_b1", 32'h80000008, 64'h0000000000001122, 8'h03);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rb_mem_valid", 64'(mem_valid), 64'd0);
    chk("rb_busy",      64'(busy),      64'd0);
    chk("rb_req_ready", 64'(req_ready), 64'd1);
    chk("rb_done",      64'(done),      64'd0);
    @(negedge clk);
    chk("rb_done_late", 64'(done), 64'd0);
    @(posedge clk); #1;

    // Further misaligned patterns checked by the model, some with a stall
    for (int i = 0; i < 4; i++) begin
      send(v_addr[i], v_data[i], v_size[i]);
      if (i % 2 == 1) begin
        mem_ready = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b1;
      end
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
